// File: rtl/pc_call_stack.sv
// -----------------------------------------------------------------------------
// pc_call_stack
//   Program counter for the RISC processor family. It supports increment,
//   absolute jump, PC-relative branch and a LIFO return-address stack for
//   CALL/RET. It drives the instruction-memory address and is steered by the
//   decode/control FSM. Exactly one action is taken per clock, chosen by
//   priority: clr > ret > call > ld > rel > inc > hold.
//
// Ports
//   clk            rising-edge clock
//   PC_clr_i       synchronous active-high reset (PC <= RESET_VEC, stack empty)
//   PC_inc_i       PC <= PC + 1
//   PC_ld_i        PC <= PC_ld_addr_i
//   PC_rel_i       PC <= PC + sign-extended PC_offset_i
//   PC_call_i      push PC + 1, PC <= PC_ld_addr_i
//   PC_ret_i       PC <= popped return address
//   PC_ld_addr_i   jump/call target
//   PC_offset_i    two's-complement branch offset
//   PC_addr_o      current PC (registered)
//   stk_count_o    number of entries on the return stack
//   stk_full_o     stack holds STK_DEPTH entries
//   stk_empty_o    stack holds no entries
//   stk_err_o      sticky overflow/underflow flag, cleared only by PC_clr_i
// -----------------------------------------------------------------------------
module pc_call_stack #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned OFF_W     = 6,
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned RESET_VEC = 32'd0
) (
  input  logic                             clk,
  input  logic                             PC_clr_i,
  input  logic                             PC_inc_i,
  input  logic                             PC_ld_i,
  input  logic                             PC_rel_i,
  input  logic                             PC_call_i,
  input  logic                             PC_ret_i,
  input  logic [ADDR_W-1:0]                PC_ld_addr_i,
  input  logic [OFF_W-1:0]                 PC_offset_i,
  output logic [ADDR_W-1:0]                PC_addr_o,
  output logic [$clog2(STK_DEPTH+1)-1:0]   stk_count_o,
  output logic                             stk_full_o,
  output logic                             stk_empty_o,
  output logic                             stk_err_o
);

  localparam int unsigned CNT_W = $clog2(STK_DEPTH + 1);
  // A single-entry stack still needs a 1-bit index.
  localparam int unsigned IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_RESET  = ADDR_W'(RESET_VEC);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(STK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] stack_q [STK_DEPTH];

  logic [ADDR_W-1:0] pc_plus1_s;
  logic [ADDR_W-1:0] off_ext_s;
  logic [IDX_W-1:0]  push_idx_s;
  logic [IDX_W-1:0]  pop_idx_s;
  logic              push_en_s;

  // Sign-extend the offset to the PC width; the add then wraps mod 2^ADDR_W.
  assign off_ext_s  = ADDR_W'($signed(PC_offset_i));
  assign pc_plus1_s = pc_q + PC_ONE;
  // The push slot is the current count; it is only used when not full, so it
  // always fits in IDX_W bits. The pop slot is count-1 and is only used when
  // not empty.
  assign push_idx_s = cnt_q[IDX_W-1:0];
  assign pop_idx_s  = IDX_W'(cnt_q - CNT_ONE);

  // Next-state selection by control priority, with one action per cycle.
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    push_en_s = 1'b0;
    if (PC_clr_i) begin
      pc_d  = PC_RESET;
      cnt_d = CNT_ZERO;
      err_d = 1'b0;
    end else if (PC_ret_i) begin
      if (empty_q) begin
        err_d = 1'b1;
      end else begin
        pc_d  = stack_q[pop_idx_s];
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (PC_call_i) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        push_en_s = 1'b1;
        cnt_d     = cnt_q + CNT_ONE;
        pc_d      = PC_ld_addr_i;
      end
    end else if (PC_ld_i) begin
      pc_d = PC_ld_addr_i;
    end else if (PC_rel_i) begin
      pc_d = pc_q + off_ext_s;
    end else if (PC_inc_i) begin
      pc_d = pc_plus1_s;
    end else begin
      pc_d = pc_q;
    end
    full_d  = (cnt_d == CNT_DEPTH);
    empty_d = (cnt_d == CNT_ZERO);
  end

  // PC and stack bookkeeping registers; PC_clr_i is folded into the _d values.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    cnt_q   <= cnt_d;
    full_q  <= full_d;
    empty_q <= empty_d;
    err_q   <= err_d;
  end

  // Return-address storage; contents are not cleared by PC_clr_i.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      stack_q[push_idx_s] <= pc_plus1_s;
    end
  end

  assign PC_addr_o   = pc_q;
  assign stk_count_o = cnt_q;
  assign stk_full_o  = full_q;
  assign stk_empty_o = empty_q;
  assign stk_err_o   = err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_call_stack
//   Directed bench for pc_call_stack (ADDR_W=8, OFF_W=6, STK_DEPTH=4,
//   RESET_VEC=0x10). Each step drives one set of controls, pushes the
//   hand-derived expected state to a scoreboard queue, and pops/compares it
//   one clock later.
// -----------------------------------------------------------------------------
module tb_pc_call_stack;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned OFF_W     = 6;
  localparam int unsigned STK_DEPTH = 4;
  localparam int unsigned CNT_W     = 3;

  // control vector order: {clr, ret, call, ld, rel, inc}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_CLR  = 6'b100000;
  localparam logic [5:0] C_RET  = 6'b010000;
  localparam logic [5:0] C_CALL = 6'b001000;
  localparam logic [5:0] C_LD   = 6'b000100;
  localparam logic [5:0] C_REL  = 6'b000010;
  localparam logic [5:0] C_INC  = 6'b000001;

  typedef struct {
    string              tag;
    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   cnt;
    logic               full;
    logic               empty;
    logic               err;
  } exp_t;

  logic              clk;
  logic              PC_clr_i, PC_inc_i, PC_ld_i, PC_rel_i, PC_call_i, PC_ret_i;
  logic [ADDR_W-1:0] PC_ld_addr_i;
  logic [OFF_W-1:0]  PC_offset_i;
  logic [ADDR_W-1:0] PC_addr_o;
  logic [CNT_W-1:0]  stk_count_o;
  logic              stk_full_o, stk_empty_o, stk_err_o;

  exp_t sb_q[$];
  int   n_assert;
  int   n_fail;

  pc_call_stack #(
    .ADDR_W   (ADDR_W),
    .OFF_W    (OFF_W),
    .STK_DEPTH(STK_DEPTH),
    .RESET_VEC(32'h10)
  ) dut (
    .clk         (clk),
    .PC_clr_i    (PC_clr_i),
    .PC_inc_i    (PC_inc_i),
    .PC_ld_i     (PC_ld_i),
    .PC_rel_i    (PC_rel_i),
    .PC_call_i   (PC_call_i),
    .PC_ret_i    (PC_ret_i),
    .PC_ld_addr_i(PC_ld_addr_i),
    .PC_offset_i (PC_offset_i),
    .PC_addr_o   (PC_addr_o),
    .stk_count_o (stk_count_o),
    .stk_full_o  (stk_full_o),
    .stk_empty_o (stk_empty_o),
    .stk_err_o   (stk_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare every output against it.
  task automatic check_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed size 0, expected an entry");
    end else begin
      e = sb_q.pop_front();
      n_assert++;
      assert (PC_addr_o === e.pc) else begin
        n_fail++;
        $error("FAIL %s.pc: observed %h expected %h", e.tag, PC_addr_o, e.pc);
      end
      n_assert++;
      assert (stk_count_o === e.cnt) else begin
        n_fail++;
        $error("FAIL %s.cnt: observed %0d expected %0d", e.tag, stk_count_o, e.cnt);
      end
      n_assert++;
      assert (stk_full_o === e.full) else begin
        n_fail++;
        $error("FAIL %s.full: observed %b expected %b", e.tag, stk_full_o, e.full);
      end
      n_assert++;
      assert (stk_empty_o === e.empty) else begin
        n_fail++;
        $error("FAIL %s.empty: observed %b expected %b", e.tag, stk_empty_o, e.empty);
      end
      n_assert++;
      assert (stk_err_o === e.err) else begin
        n_fail++;
        $error("FAIL %s.err: observed %b expected %b", e.tag, stk_err_o, e.err);
      end
    end
  endtask

  // Drive one cycle of controls, record the expected result, then check it.
  task automatic step(input string tag, input logic [5:0] ctl,
                      input logic [ADDR_W-1:0] addr, input logic [OFF_W-1:0] off,
                      input logic [ADDR_W-1:0] e_pc, input logic [CNT_W-1:0] e_cnt,
                      input logic e_err);
    exp_t e;
    @(negedge clk);
    {PC_clr_i, PC_ret_i, PC_call_i, PC_ld_i, PC_rel_i, PC_inc_i} = ctl;
    PC_ld_addr_i = addr;
    PC_offset_i  = off;
    e.tag   = tag;
    e.pc    = e_pc;
    e.cnt   = e_cnt;
    e.full  = (e_cnt == 3'd4);
    e.empty = (e_cnt == 3'd0);
    e.err   = e_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    {PC_clr_i, PC_ret_i, PC_call_i, PC_ld_i, PC_rel_i, PC_inc_i} = C_NONE;
    PC_ld_addr_i = 8'h00;
    PC_offset_i  = 6'h00;

    // 1 reset
    step("reset",    C_CLR,  8'h00, 6'h00, 8'h10, 3'd0, 1'b0);
    step("hold",     C_NONE, 8'hAA, 6'h00, 8'h10, 3'd0, 1'b0);

    // 2 increment wrap
    step("ld_fe",    C_LD,   8'hFE, 6'h00, 8'hFE, 3'd0, 1'b0);
    step("inc_ff",   C_INC,  8'h00, 6'h00, 8'hFF, 3'd0, 1'b0);
    step("inc_00",   C_INC,  8'h00, 6'h00, 8'h00, 3'd0, 1'b0);
    step("inc_01",   C_INC,  8'h00, 6'h00, 8'h01, 3'd0, 1'b0);

    // 3 relative branch, wrapping both ways
    step("ld_05",    C_LD,   8'h05, 6'h00, 8'h05, 3'd0, 1'b0);
    step("rel_m2",   C_REL,  8'h00, 6'h3E, 8'h03, 3'd0, 1'b0);
    step("ld_01",    C_LD,   8'h01, 6'h00, 8'h01, 3'd0, 1'b0);
    step("rel_wrapd",C_REL,  8'h00, 6'h3E, 8'hFF, 3'd0, 1'b0);
    step("ld_fc",    C_LD,   8'hFC, 6'h00, 8'hFC, 3'd0, 1'b0);
    step("rel_wrapu",C_REL,  8'h00, 6'h08, 8'h04, 3'd0, 1'b0);
    step("rel_min",  C_REL,  8'h00, 6'h20, 8'hE4, 3'd0, 1'b0);
    step("ld_prio",  C_LD | C_REL | C_INC, 8'h77, 6'h01, 8'h77, 3'd0, 1'b0);

    // 4 nested call/return
    step("ld_20",    C_LD,   8'h20, 6'h00, 8'h20, 3'd0, 1'b0);
    step("call_40",  C_CALL, 8'h40, 6'h00, 8'h40, 3'd1, 1'b0);
    step("call_80",  C_CALL, 8'h80, 6'h00, 8'h80, 3'd2, 1'b0);
    step("ret_41",   C_RET,  8'h00, 6'h00, 8'h41, 3'd1, 1'b0);
    step("ret_21",   C_RET,  8'h00, 6'h00, 8'h21, 3'd0, 1'b0);

    // return address wraps when calling from the top address
    step("ld_ff",    C_LD,   8'hFF, 6'h00, 8'hFF, 3'd0, 1'b0);
    step("call_wrap",C_CALL, 8'h08, 6'h00, 8'h08, 3'd1, 1'b0);
    step("ret_wrap", C_RET,  8'h00, 6'h00, 8'h00, 3'd0, 1'b0);

    // 5 overflow then underflow
    step("ovf_c1",   C_CALL, 8'h30, 6'h00, 8'h30, 3'd1, 1'b0);
    step("ovf_c2",   C_CALL, 8'h31, 6'h00, 8'h31, 3'd2, 1'b0);
    step("ovf_c3",   C_CALL, 8'h32, 6'h00, 8'h32, 3'd3, 1'b0);
    step("ovf_c4",   C_CALL, 8'h33, 6'h00, 8'h33, 3'd4, 1'b0);
    step("ovf_c5",   C_CALL, 8'h34, 6'h00, 8'h33, 3'd4, 1'b1);
    step("err_stky", C_INC,  8'h00, 6'h00, 8'h34, 3'd4, 1'b1);
    step("ret_full", C_RET,  8'h00, 6'h00, 8'h33, 3'd3, 1'b1);
    step("clr_err",  C_CLR,  8'h00, 6'h00, 8'h10, 3'd0, 1'b0);
    step("unf_ret",  C_RET,  8'h00, 6'h00, 8'h10, 3'd0, 1'b1);
    step("unf_hold", C_NONE, 8'h00, 6'h00, 8'h10, 3'd0, 1'b1);

    // 6 priority and reset mid-operation
    step("p_clr",    C_CLR,  8'h00, 6'h00, 8'h10, 3'd0, 1'b0);
    step("p_ld50",   C_LD,   8'h50, 6'h00, 8'h50, 3'd0, 1'b0);
    step("p_call60", C_CALL, 8'h60, 6'h00, 8'h60, 3'd1, 1'b0);
    step("p_call70", C_CALL, 8'h70, 6'h00, 8'h70, 3'd2, 1'b0);
    step("p_retonly",C_RET | C_CALL | C_INC, 8'h90, 6'h00, 8'h61, 3'd1, 1'b0);
    step("p_call72", C_CALL, 8'h72, 6'h00, 8'h72, 3'd2, 1'b0);
    step("p_clrcall",C_CLR | C_CALL, 8'h99, 6'h00, 8'h10, 3'd0, 1'b0);
    step("p_after",  C_RET,  8'h00, 6'h00, 8'h10, 3'd0, 1'b1);

    if (sb_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
